dncntr_timer: RTL and testbench
===============================

# dncntr_timer

Loadable down-counting timer. It counts a loaded value down to zero, raises a one-cycle terminal-count strobe, and then either stops (one-shot) or reloads and runs again (periodic). It is the counting-down companion to the team's loadable binary up-counter. It sits beside the BCD and FSM blocks as the timebase and delay generator for controllers that need "wait N cycles" or a periodic tick.

## Interface
Parameters:
- WIDTH, 4: counter and load-value width in bits.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- d  input  WIDTH  load value.
- ld  input  1  synchronous load and abort. Copies d into q and into the reload register, and forces IDLE.
- start  input  1  begins counting when in IDLE.
- pause  input  1  level-sensitive freeze while counting.
- periodic  input  1  sampled in EXPIRE: 1 = reload and rerun, 0 = stop.
- q  output  WIDTH  current count.
- busy  output  1  high in RUN or HOLD.
- tc  output  1  terminal-count strobe, high exactly while state is EXPIRE.

## Operation
- States: IDLE, RUN, HOLD, EXPIRE. The state is registered. busy and tc decode directly from state flops, so they are glitch-free.
- Reset (rst=0, asynchronous):
  - q=0 and reload=0.
  - state=IDLE, busy=0, tc=0.
- Priority on every edge: ld > start > count logic.
- ld=1 in any state:
  - q<=d and reload<=d.
  - state<=IDLE, whatever the other inputs.
  - If state was EXPIRE, tc is still high in that cycle; it drops on the ld edge.
- IDLE:
  - start=1 and q!=0: go to RUN. q does not change on this edge.
  - start=1 and q==0: go to EXPIRE. This gives an immediate tc.
  - start=0: hold.
- RUN or HOLD, pause=0:
  - q<=q-1 and state<=RUN.
  - If q==1, q becomes 0 and state<=EXPIRE instead.
- RUN or HOLD, pause=1: q holds and state<=HOLD. A pause on the final decrement delays the expiry.
- start while busy: ignored.
- EXPIRE (lasts one cycle, q==0):
  - periodic=1 and reload!=0: q<=reload and state<=RUN.
  - Otherwise: q stays 0 and state<=IDLE.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - The decrement is only enabled for q>=1, so q never wraps to all-ones.
  - The reload value is the last value loaded with ld; it is never modified by counting.
- Reset mid-count: everything returns to reset values immediately. No tc is generated.

## Timing
- One-shot latency: with q=N (N>=1), the start edge is followed by N decrement edges. tc is high during the cycle after the Nth decrement, and busy drops on that same edge.
- Periodic: tc period is N+1 cycles. The EXPIRE cycle counts as the zero state. No gaps occur and no extra cycles are inserted.
- busy rises the cycle after the start edge.
- tc width is exactly 1 cycle, except that paused cycles stretch only the counting phase, never tc.
- Every output changes only on a clk rising edge or asynchronously on rst falling.

## Structure
- Shared package cntr_pkg holds:
  - the state typedef: IDLE=2'b00, RUN=2'b01, HOLD=2'b10, EXPIRE=2'b11.
  - the default width constant, CNTR_W=4.
- One sub-module is natural: dncntr_core. It is the loadable down-count register, with inputs ld/dec/d, output q, and a zero flag (q==0) and a one flag (q==1).
- dncntr_timer adds the FSM, the reload register and the output decode.

## Test plan
- Reset: drive rst=0 mid-count with q=5 -> q=0, busy=0 and tc=0 immediately (asynchronous). They stay there after release until ld.
- One-shot: ld with d=3, then start, periodic=0.
  - q: 3, 3, 2, 1, 0 on successive edges.
  - tc high for exactly 1 cycle when q=0.
  - busy low from that cycle; stays IDLE.
- Periodic: d=2, start, periodic=1 -> q: 2, 1, 0, 2, 1, 0, ... with tc every 3 cycles. Clearing periodic ends the run at the next EXPIRE.
- Pause: d=4, start, and pause=1 for 3 cycles while q=2 -> q holds at 2, state is HOLD, busy=1. After release, q: 1, 0 and tc fires 3 cycles later than unpaused.
- Zero and abort:
  - start with q=0 -> tc on the next cycle, no RUN.
  - ld with d=9 during RUN at q=6 -> q=9, state IDLE, no tc.
  - ld and start together -> ld wins, stays IDLE.
- Width sweep: WIDTH=8 with d=8'hFF, one-shot -> tc after exactly 255 decrements; q never wraps.

Source files
------------

// File: rtl/cntr_pkg.sv
// cntr_pkg: shared state encoding and default width for the counter family.
package cntr_pkg;
  localparam int CNTR_W = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HOLD   = 2'b10,
    EXPIRE = 2'b11
  } state_t;
endpackage

// File: rtl/dncntr_core.sv
// dncntr_core: loadable down-count register with zero and one flags.
module dncntr_core import cntr_pkg::*; #(
  parameter int WIDTH = CNTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             one
);
  assign zero = q == '0;
  assign one  = q == WIDTH'(1);
  // Decrement is gated on nonzero so the count can never wrap to all-ones.
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (ld) q <= d;
    else if (dec && !zero) q <= q - WIDTH'(1);
endmodule

// File: rtl/dncntr_timer.sv
// dncntr_timer: loadable down-counting timer with one-shot/periodic modes,
// pause, and a one-cycle terminal-count strobe decoded from state flops.
module dncntr_timer import cntr_pkg::*; #(
  parameter int WIDTH = CNTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  input  logic             start,
  input  logic             pause,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] reload;
  logic zero, one, counting, rearm, dec, core_ld;
  assign counting = state == RUN || state == HOLD;
  assign rearm    = state == EXPIRE && periodic && reload != '0;
  assign dec      = counting && !pause && !ld;
  assign core_ld  = ld || rearm;
  dncntr_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .ld   (core_ld),
    .dec  (dec),
    .d    (ld ? d : reload),
    .q    (q),
    .zero (zero),
    .one  (one)
  );
  always_comb
    state_nxt = ld ? IDLE :
                state == IDLE ? (start ? (zero ? EXPIRE : RUN) : IDLE) :
                counting ? (pause ? HOLD : one ? EXPIRE : RUN) :
                rearm ? RUN : IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      reload <= '0;
    end else begin
      state <= state_nxt;
      if (ld) reload <= d;
    end
  assign busy = counting;
  assign tc   = state == EXPIRE;
endmodule

// File: tb/tb_dncntr_timer.sv
// tb_dncntr_timer: scoreboard bench with a rule-level timer model and random stimulus.
module tb_dncntr_timer;
  logic clk = 0, rst = 0;
  logic [3:0] d = 0;
  logic ld = 0, start = 0, pause = 0, periodic = 0;
  logic [3:0] q;
  logic busy, tc;
  logic [7:0] d8 = 0, q8;
  logic ld8 = 0, start8 = 0, busy8, tc8;
  int checks = 0, errors = 0;
  logic [5:0] sb[$];
  logic [3:0] mq = 0, mrel = 0;
  logic mbusy = 0, mtc = 0;

  always #5 clk = ~clk;

  dncntr_timer u_dut (.clk(clk), .rst(rst), .d(d), .ld(ld), .start(start), .pause(pause),
                      .periodic(periodic), .q(q), .busy(busy), .tc(tc));
  dncntr_timer #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .d(d8), .ld(ld8), .start(start8),
                      .pause(1'b0), .periodic(1'b0), .q(q8), .busy(busy8), .tc(tc8));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a timer is either idle, counting (busy), or in its single expiry cycle (tc).
  task automatic cyc(input logic l, input logic s, input logic p, input logic pr, input logic [3:0] dv);
    @(negedge clk);
    ld = l; start = s; pause = p; periodic = pr; d = dv;
    if (l) begin
      mq = dv; mrel = dv; mbusy = 0; mtc = 0;
    end else if (mtc) begin
      mtc = 0;
      mbusy = pr && mrel != 0;
      if (mbusy) mq = mrel;
    end else if (mbusy) begin
      if (!p) begin
        mq = mq - 1;
        if (mq == 0) begin mbusy = 0; mtc = 1; end
      end
    end else if (s) begin
      if (mq == 0) mtc = 1; else mbusy = 1;
    end
    sb.push_back({mq, mbusy, mtc});
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rst && sb.size() > 0) begin
      logic [5:0] e;
      e = sb.pop_front();
      check("q", q, e[5:2]);
      check("busy", busy, e[1]);
      check("tc", tc, e[0]);
    end
  end

  initial begin
    #1;
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_tc", tc, 0);
    @(negedge clk);
    rst = 1;
    // one-shot from 3
    cyc(1, 0, 0, 0, 3);
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    // periodic from 2, then clear periodic
    cyc(1, 0, 0, 0, 2);
    cyc(0, 1, 0, 1, 0);
    repeat (8) cyc(0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    // pause 3 cycles at q=2
    cyc(1, 0, 0, 0, 4);
    cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    // start with q=0, ld during run, ld with start
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 8);
    cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 9);
    cyc(1, 1, 0, 0, 5);
    repeat (2) cyc(0, 0, 0, 0, 0);
    // periodic with reload 0 stops
    cyc(1, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    // random
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, 4'($urandom));
    // async reset mid-count at q=5
    cyc(1, 0, 0, 0, 7);
    cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("pre_reset_q", q, 5);
    rst = 0;
    #1;
    check("async_q", q, 0);
    check("async_busy", busy, 0);
    check("async_tc", tc, 0);
    mq = 0; mrel = 0; mbusy = 0; mtc = 0;
    @(negedge clk);
    rst = 1;
    repeat (3) cyc(0, 0, 1, 1, 4'hA);
    // 8-bit sweep: 255 decrements to tc
    @(negedge clk);
    ld = 0; start = 0; pause = 0; periodic = 0;
    ld8 = 1; d8 = 8'hFF;
    @(negedge clk);
    ld8 = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    begin
      int n;
      logic wrap;
      logic [7:0] prev;
      n = 0; wrap = 0; prev = q8;
      while (!tc8 && n < 300) begin
        @(posedge clk);
        #1;
        n++;
        if (q8 > prev) wrap = 1;
        prev = q8;
      end
      check("w8_edges", n, 255);
      check("w8_wrap", wrap, 0);
      check("w8_q", q8, 0);
      @(posedge clk);
      #1;
      check("w8_idle", {busy8, tc8}, 0);
    end
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
